cpu_dexe_reg: RTL and testbench

- Decode-to-execute pipeline register and hazard controller for the 8-bit pipelined core.
- Sits directly downstream of the operand forwarding network. It latches the forwarded operand values (A/B) and decode control into the E stage.
- It detects load-use and late-result hazards that forwarding cannot resolve (result not yet computed), stalls F/D, and inserts E-stage bubbles.
- It also flushes on branch mispredict and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/cpu_dexe_reg.sv | 146 ++++++++++++++
 tb/tb_cpu_dexe_reg.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dexe_reg.sv
// Decode-to-execute pipeline register with hazard control.
// Latches forwarded operands and decode control into the E stage, stalls F/D
// on hazards forwarding cannot cover, inserts bubbles, flushes on mispredict,
// and counts stall cycles with a saturating counter.
module cpu_dexe_reg #(
    parameter int CNT_W = 16
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             D_VALID_I,
    input  logic [3:0]       D_ICODE_I,
    input  logic [2:0]       D_SRCA_I,
    input  logic             D_SRCA_CS_I,
    input  logic [2:0]       D_SRCB_I,
    input  logic             D_SRCB_CS_I,
    input  logic [7:0]       D_VALA_I,
    input  logic [7:0]       D_VALB_I,
    input  logic [2:0]       D_DSTR_I,
    input  logic             D_DSTR_CS_I,
    input  logic [2:0]       E_DSTR_I,
    input  logic             E_VALID_I,
    input  logic             E_DSTR_CS_E_I,
    input  logic             E_DSTR_CS_M_I,
    input  logic [2:0]       M_DSTR_I,
    input  logic             M_VALID_I,
    input  logic             M_DSTR_CS_M_I,
    input  logic             FLUSH_I,
    output logic             E_VALID_O,
    output logic [3:0]       E_ICODE_O,
    output logic [7:0]       E_VALA_O,
    output logic [7:0]       E_VALB_O,
    output logic [2:0]       E_DSTR_O,
    output logic             E_DSTR_CS_O,
    output logic             STALL_FD_O,
    output logic [CNT_W-1:0] STALL_CNT_O
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL1 = 2'd1,
        ST_STALL2 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_srca_e;
    logic             w_srcb_e;
    logic             w_srca_m;
    logic             w_srcb_m;
    logic             w_haz_e;
    logic             w_haz_m;
    logic             w_stall;
    logic             w_bubble;

    logic             r_e_valid;
    logic [3:0]       r_e_icode;
    logic [7:0]       r_e_vala;
    logic [7:0]       r_e_valb;
    logic [2:0]       r_e_dstr;
    logic             r_e_dstr_cs;
    logic [CNT_W-1:0] r_stall_cnt;

    // Source matches; an invalid D instruction never matches anything.
    assign w_srca_e = D_SRCA_CS_I & E_VALID_I & D_VALID_I & (D_SRCA_I == E_DSTR_I);
    assign w_srcb_e = D_SRCB_CS_I & E_VALID_I & D_VALID_I & (D_SRCB_I == E_DSTR_I);
    assign w_srca_m = D_SRCA_CS_I & M_VALID_I & D_VALID_I & (D_SRCA_I == M_DSTR_I);
    assign w_srcb_m = D_SRCB_CS_I & M_VALID_I & D_VALID_I & (D_SRCB_I == M_DSTR_I);

    // E producers are late for both ALU and memory results; M only for memory.
    assign w_haz_e  = (w_srca_e | w_srcb_e) & (E_DSTR_CS_E_I | E_DSTR_CS_M_I);
    assign w_haz_m  = (w_srca_m | w_srcb_m) & M_DSTR_CS_M_I;

    // Flush kills the instruction in D, so there is nothing left to stall for.
    assign w_stall    = (w_haz_e | w_haz_m) & ~FLUSH_I;
    assign w_bubble   = FLUSH_I | w_stall;
    assign STALL_FD_O = w_stall;

    // E-stage register: bubble on flush or stall, otherwise take D.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_e_valid   <= 1'b0;
            r_e_icode   <= 4'd0;
            r_e_vala    <= 8'd0;
            r_e_valb    <= 8'd0;
            r_e_dstr    <= 3'd0;
            r_e_dstr_cs <= 1'b0;
        end else if (w_bubble) begin
            r_e_valid   <= 1'b0;
            r_e_icode   <= 4'd0;
            r_e_vala    <= 8'd0;
            r_e_valb    <= 8'd0;
            r_e_dstr    <= 3'd0;
            r_e_dstr_cs <= 1'b0;
        end else begin
            r_e_valid   <= D_VALID_I;
            r_e_icode   <= D_ICODE_I;
            r_e_vala    <= D_VALA_I;
            r_e_valb    <= D_VALB_I;
            r_e_dstr    <= D_DSTR_I;
            r_e_dstr_cs <= D_DSTR_CS_I & D_VALID_I;
        end
    end

    // Saturating stall-cycle counter; only reset clears it.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Stall-sequence state register.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tracks which stall cycle we are in; STALL2 means the load reached M.
    always_comb begin
        w_state_nxt = r_state;
        if (FLUSH_I) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:    if (w_stall) w_state_nxt = ST_STALL1;
                ST_STALL1: w_state_nxt = w_haz_m ? ST_STALL2 : ST_RUN;
                ST_STALL2: w_state_nxt = ST_RUN;
                default:   w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign E_VALID_O   = r_e_valid;
    assign E_ICODE_O   = r_e_icode;
    assign E_VALA_O    = r_e_vala;
    assign E_VALB_O    = r_e_valb;
    assign E_DSTR_O    = r_e_dstr;
    assign E_DSTR_CS_O = r_e_dstr_cs;
    assign STALL_CNT_O = r_stall_cnt;

endmodule

// File: tb/tb_cpu_dexe_reg.sv
// Self-checking bench for cpu_dexe_reg: a reference model pushes expected
// E-stage/stall/counter values per cycle, observations are popped and compared.
module tb_cpu_dexe_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_valid, d_srca_cs, d_srcb_cs, d_dstr_cs;
    logic [3:0] d_icode;
    logic [2:0] d_srca, d_srcb, d_dstr;
    logic [7:0] d_vala, d_valb;
    logic [2:0] e_dstr, m_dstr;
    logic       e_valid, e_cs_e, e_cs_m, m_valid, m_cs_m, flush;

    logic        e_valid_o, e_dstr_cs_o, stall_o;
    logic [3:0]  e_icode_o;
    logic [7:0]  e_vala_o, e_valb_o;
    logic [2:0]  e_dstr_o;
    logic [15:0] cnt16;

    logic        e_valid_o4, e_dstr_cs_o4, stall_o4;
    logic [3:0]  e_icode_o4;
    logic [7:0]  e_vala_o4, e_valb_o4;
    logic [2:0]  e_dstr_o4;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    cpu_dexe_reg #(.CNT_W(16)) dut (
        .CLK_I(clk), .RST_I(rst), .D_VALID_I(d_valid), .D_ICODE_I(d_icode),
        .D_SRCA_I(d_srca), .D_SRCA_CS_I(d_srca_cs), .D_SRCB_I(d_srcb),
        .D_SRCB_CS_I(d_srcb_cs), .D_VALA_I(d_vala), .D_VALB_I(d_valb),
        .D_DSTR_I(d_dstr), .D_DSTR_CS_I(d_dstr_cs), .E_DSTR_I(e_dstr),
        .E_VALID_I(e_valid), .E_DSTR_CS_E_I(e_cs_e), .E_DSTR_CS_M_I(e_cs_m),
        .M_DSTR_I(m_dstr), .M_VALID_I(m_valid), .M_DSTR_CS_M_I(m_cs_m),
        .FLUSH_I(flush), .E_VALID_O(e_valid_o), .E_ICODE_O(e_icode_o),
        .E_VALA_O(e_vala_o), .E_VALB_O(e_valb_o), .E_DSTR_O(e_dstr_o),
        .E_DSTR_CS_O(e_dstr_cs_o), .STALL_FD_O(stall_o), .STALL_CNT_O(cnt16)
    );

    cpu_dexe_reg #(.CNT_W(4)) dut4 (
        .CLK_I(clk), .RST_I(rst), .D_VALID_I(d_valid), .D_ICODE_I(d_icode),
        .D_SRCA_I(d_srca), .D_SRCA_CS_I(d_srca_cs), .D_SRCB_I(d_srcb),
        .D_SRCB_CS_I(d_srcb_cs), .D_VALA_I(d_vala), .D_VALB_I(d_valb),
        .D_DSTR_I(d_dstr), .D_DSTR_CS_I(d_dstr_cs), .E_DSTR_I(e_dstr),
        .E_VALID_I(e_valid), .E_DSTR_CS_E_I(e_cs_e), .E_DSTR_CS_M_I(e_cs_m),
        .M_DSTR_I(m_dstr), .M_VALID_I(m_valid), .M_DSTR_CS_M_I(m_cs_m),
        .FLUSH_I(flush), .E_VALID_O(e_valid_o4), .E_ICODE_O(e_icode_o4),
        .E_VALA_O(e_vala_o4), .E_VALB_O(e_valb_o4), .E_DSTR_O(e_dstr_o4),
        .E_DSTR_CS_O(e_dstr_cs_o4), .STALL_FD_O(stall_o4), .STALL_CNT_O(cnt4)
    );

    typedef struct {
        logic        v;
        logic [3:0]  ic;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  d;
        logic        cs;
        logic        st;
        logic        st4;
        logic [15:0] c16;
        logic [3:0]  c4;
    } snap_t;

    snap_t       exp_q[$];
    snap_t       obs_q[$];
    snap_t       e, o, last;
    logic [15:0] m_c16;
    logic [3:0]  m_c4;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic clear_inputs();
        d_valid = 0; d_icode = 0; d_srca = 0; d_srca_cs = 0; d_srcb = 0; d_srcb_cs = 0;
        d_vala = 0; d_valb = 0; d_dstr = 0; d_dstr_cs = 0;
        e_dstr = 0; e_valid = 0; e_cs_e = 0; e_cs_m = 0;
        m_dstr = 0; m_valid = 0; m_cs_m = 0; flush = 0;
    endtask

    task automatic set_d(input logic v, input logic [3:0] ic, input logic [2:0] sa,
                         input logic sacs, input logic [2:0] sb, input logic sbcs,
                         input logic [7:0] va, input logic [7:0] vb,
                         input logic [2:0] ds, input logic dscs);
        d_valid = v; d_icode = ic; d_srca = sa; d_srca_cs = sacs; d_srcb = sb;
        d_srcb_cs = sbcs; d_vala = va; d_valb = vb; d_dstr = ds; d_dstr_cs = dscs;
    endtask

    // Entered at posedge+1. Predicts this cycle, records outputs, returns at next posedge+1.
    task automatic step();
        snap_t x, y;
        logic  he, hm;
        he = d_valid & e_valid & (e_cs_e | e_cs_m) &
             ((d_srca_cs & (d_srca == e_dstr)) | (d_srcb_cs & (d_srcb == e_dstr)));
        hm = d_valid & m_valid & m_cs_m &
             ((d_srca_cs & (d_srca == m_dstr)) | (d_srcb_cs & (d_srcb == m_dstr)));
        x.st  = (he | hm) & ~flush;
        x.st4 = x.st;
        if (flush || x.st) begin
            x.v = 0; x.ic = 0; x.a = 0; x.b = 0; x.d = 0; x.cs = 0;
        end else begin
            x.v = d_valid; x.ic = d_icode; x.a = d_vala; x.b = d_valb; x.d = d_dstr;
            x.cs = d_dstr_cs & d_valid;
        end
        if (x.st) begin
            if (m_c16 != 16'hFFFF) m_c16 = m_c16 + 16'd1;
            if (m_c4 != 4'hF) m_c4 = m_c4 + 4'd1;
        end
        x.c16 = m_c16; x.c4 = m_c4;
        exp_q.push_back(x);
        #1;
        y.st = stall_o; y.st4 = stall_o4;
        @(posedge clk); #1;
        y.v = e_valid_o; y.ic = e_icode_o; y.a = e_vala_o; y.b = e_valb_o;
        y.d = e_dstr_o; y.cs = e_dstr_cs_o; y.c16 = cnt16; y.c4 = cnt4;
        obs_q.push_back(y);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_c16 = 0; m_c4 = 0;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        m_c16 = 0; m_c4 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if ({e_valid_o, e_icode_o, e_vala_o, e_valb_o, e_dstr_o, e_dstr_cs_o, cnt16, cnt4} !== 42'd0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b ic=%h a=%h b=%h d=%h cs=%b c16=%h c4=%h, want all 0",
                     e_valid_o, e_icode_o, e_vala_o, e_valb_o, e_dstr_o, e_dstr_cs_o, cnt16, cnt4);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_pass();
        clear_inputs();
        set_d(1, 4'd3, 3'd5, 1, 3'd6, 1, 8'h12, 8'h34, 3'd2, 1);
        step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); last = o;
            n_vec++;
            if ({o.st, o.st4} !== {e.st, e.st4}) begin n_err++; $display("FAIL pass stall: got %b%b want %b%b", o.st, o.st4, e.st, e.st4); end
            n_vec++;
            if ({o.v, o.ic, o.a, o.b, o.d, o.cs} !== {e.v, e.ic, e.a, e.b, e.d, e.cs}) begin
                n_err++; $display("FAIL pass e_regs: got v=%b ic=%h a=%h b=%h d=%h cs=%b want v=%b ic=%h a=%h b=%h d=%h cs=%b",
                                  o.v, o.ic, o.a, o.b, o.d, o.cs, e.v, e.ic, e.a, e.b, e.d, e.cs);
            end
        end
        n_vec++;
        if ({last.v, last.ic, last.a, last.b, last.d, last.cs, last.st} !== {1'b1, 4'd3, 8'h12, 8'h34, 3'd2, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL pass literal: got v=%b ic=%h a=%h b=%h d=%h st=%b want 1 3 12 34 2 0",
                              last.v, last.ic, last.a, last.b, last.d, last.st);
        end
    endtask

    task automatic test_load_use();
        logic [2:0]  stseq, vseq;
        logic [15:0] c0;
        c0 = m_c16; stseq = 0; vseq = 0;
        clear_inputs();
        set_d(1, 4'd7, 3'd4, 1, 3'd0, 0, 8'hA5, 8'h5A, 3'd3, 1);
        e_valid = 1; e_dstr = 3'd4; e_cs_m = 1;
        step();
        e_valid = 0; e_cs_m = 0; m_valid = 1; m_dstr = 3'd4; m_cs_m = 1;
        step();
        m_valid = 0; m_cs_m = 0;
        step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); last = o;
            stseq = {stseq[1:0], o.st}; vseq = {vseq[1:0], o.v};
            n_vec++;
            if ({o.v, o.ic, o.a, o.b, o.d, o.cs, o.st} !== {e.v, e.ic, e.a, e.b, e.d, e.cs, e.st}) begin
                n_err++; $display("FAIL load_use cycle: got v=%b ic=%h a=%h st=%b want v=%b ic=%h a=%h st=%b",
                                  o.v, o.ic, o.a, o.st, e.v, e.ic, e.a, e.st);
            end
        end
        n_vec++;
        if ({stseq, vseq} !== 6'b110_001) begin
            n_err++; $display("FAIL load_use seq: got stall=%b valid=%b want 110 001", stseq, vseq);
        end
        n_vec++;
        if (last.c16 !== c0 + 16'd2) begin
            n_err++; $display("FAIL load_use cnt: got %0d want %0d", last.c16, c0 + 16'd2);
        end
    endtask

    task automatic test_alu_late();
        logic [1:0]  stseq;
        logic [15:0] c0;
        c0 = m_c16; stseq = 0;
        clear_inputs();
        set_d(1, 4'd9, 3'd0, 0, 3'd1, 1, 8'h3C, 8'hC3, 3'd6, 1);
        e_valid = 1; e_dstr = 3'd1; e_cs_e = 1;
        step();
        e_valid = 0; e_cs_e = 0; m_valid = 1; m_dstr = 3'd1; m_cs_m = 0;
        step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); last = o;
            stseq = {stseq[0], o.st};
            n_vec++;
            if ({o.v, o.ic, o.a, o.b, o.d, o.cs, o.st, o.c16} !== {e.v, e.ic, e.a, e.b, e.d, e.cs, e.st, e.c16}) begin
                n_err++; $display("FAIL alu_late cycle: got v=%b ic=%h st=%b c=%0d want v=%b ic=%h st=%b c=%0d",
                                  o.v, o.ic, o.st, o.c16, e.v, e.ic, e.st, e.c16);
            end
        end
        n_vec++;
        if ({stseq, last.v, last.c16} !== {2'b10, 1'b1, c0 + 16'd1}) begin
            n_err++; $display("FAIL alu_late literal: got stall=%b v=%b cnt=%0d want 10 1 %0d",
                              stseq, last.v, last.c16, c0 + 16'd1);
        end
    endtask

    task automatic test_flush_stall();
        logic [15:0] c0;
        c0 = m_c16;
        clear_inputs();
        set_d(1, 4'd2, 3'd0, 0, 3'd1, 1, 8'h77, 8'h88, 3'd1, 1);
        e_valid = 1; e_dstr = 3'd1; e_cs_e = 1; flush = 1;
        step();
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_vec++;
        if ({o.st, o.v, o.cs, o.ic, o.c16} !== {1'b0, 1'b0, 1'b0, 4'd0, c0}) begin
            n_err++; $display("FAIL flush_stall: got st=%b v=%b cs=%b ic=%h cnt=%0d want 0 0 0 0 %0d",
                              o.st, o.v, o.cs, o.ic, o.c16, c0);
        end
        n_vec++;
        if ({o.st, o.v, o.a, o.c16} !== {e.st, e.v, e.a, e.c16}) begin
            n_err++; $display("FAIL flush_model: got st=%b v=%b a=%h want st=%b v=%b a=%h", o.st, o.v, o.a, e.st, e.v, e.a);
        end
    endtask

    task automatic test_invalid_d();
        logic [15:0] c0;
        c0 = m_c16;
        clear_inputs();
        set_d(0, 4'd6, 3'd2, 1, 3'd3, 1, 8'h11, 8'h22, 3'd5, 1);
        e_valid = 1; e_dstr = 3'd2; e_cs_m = 1; m_valid = 1; m_dstr = 3'd3; m_cs_m = 1;
        step();
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_vec++;
        if ({o.st, o.st4, o.v, o.cs, o.c16} !== {1'b0, 1'b0, 1'b0, 1'b0, c0}) begin
            n_err++; $display("FAIL invalid_d: got st=%b v=%b cs=%b cnt=%0d want 0 0 0 %0d",
                              o.st, o.v, o.cs, o.c16, c0);
        end
        n_vec++;
        if ({o.ic, o.a, o.b, o.d} !== {e.ic, e.a, e.b, e.d}) begin
            n_err++; $display("FAIL invalid_d data: got ic=%h a=%h b=%h d=%h want ic=%h a=%h b=%h d=%h",
                              o.ic, o.a, o.b, o.d, e.ic, e.a, e.b, e.d);
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        do_reset();
        set_d(1, 4'd1, 3'd7, 1, 3'd0, 0, 8'h01, 8'h02, 3'd3, 1);
        e_valid = 1; e_dstr = 3'd7; e_cs_e = 1;
        for (int i = 0; i < 20; i++) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); last = o;
            n_vec++;
            if ({o.st, o.st4, o.v, o.c16, o.c4} !== {e.st, e.st4, e.v, e.c16, e.c4}) begin
                n_err++; $display("FAIL saturation cycle: got st=%b v=%b c16=%0d c4=%0d want st=%b v=%b c16=%0d c4=%0d",
                                  o.st, o.v, o.c16, o.c4, e.st, e.v, e.c16, e.c4);
            end
        end
        n_vec++;
        if ({last.c4, last.c16} !== {4'hF, 16'd20}) begin
            n_err++; $display("FAIL saturation final: got c4=%h c16=%0d want F 20", last.c4, last.c16);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        for (int i = 0; i < 300; i++) begin
            set_d(1'($urandom_range(0, 3) != 0), 4'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                  3'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 3)), 1'($urandom));
            e_valid = 1'($urandom); e_dstr = 3'($urandom_range(0, 3));
            e_cs_e = 1'($urandom); e_cs_m = 1'($urandom);
            m_valid = 1'($urandom); m_dstr = 3'($urandom_range(0, 3)); m_cs_m = 1'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            step();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if ({o.v, o.ic, o.a, o.b, o.d, o.cs, o.st, o.st4, o.c16, o.c4} !==
                {e.v, e.ic, e.a, e.b, e.d, e.cs, e.st, e.st4, e.c16, e.c4}) begin
                n_err++; $display("FAIL random: got v=%b ic=%h a=%h b=%h d=%h cs=%b st=%b c16=%0d c4=%0d want v=%b ic=%h a=%h b=%h d=%h cs=%b st=%b c16=%0d c4=%0d",
                                  o.v, o.ic, o.a, o.b, o.d, o.cs, o.st, o.c16, o.c4,
                                  e.v, e.ic, e.a, e.b, e.d, e.cs, e.st, e.c16, e.c4);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        do_reset();
        set_d(1, 4'd4, 3'd0, 0, 3'd5, 1, 8'h99, 8'h66, 3'd4, 1);
        e_valid = 1; e_dstr = 3'd5; e_cs_e = 1;
        for (int i = 0; i < 5; i++) step();
        e_valid = 0; e_cs_e = 0;
        step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); last = o;
            n_vec++;
            if ({o.v, o.ic, o.a, o.st, o.c16} !== {e.v, e.ic, e.a, e.st, e.c16}) begin
                n_err++; $display("FAIL rst_mid prefill: got v=%b ic=%h a=%h st=%b c=%0d want v=%b ic=%h a=%h st=%b c=%0d",
                                  o.v, o.ic, o.a, o.st, o.c16, e.v, e.ic, e.a, e.st, e.c16);
            end
        end
        n_vec++;
        if ({last.c16, last.v, last.ic} !== {16'd5, 1'b1, 4'd4}) begin
            n_err++; $display("FAIL rst_mid setup: got cnt=%0d v=%b ic=%h want 5 1 4", last.c16, last.v, last.ic);
        end
        e_valid = 1; e_cs_e = 1;
        #2;
        n_vec++;
        if (stall_o !== 1'b1) begin
            n_err++; $display("FAIL rst_mid stalling: got %b want 1", stall_o);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({e_valid_o, e_icode_o, e_vala_o, e_valb_o, e_dstr_o, e_dstr_cs_o, cnt16, cnt4} !== 42'd0) begin
            n_err++; $display("FAIL rst_mid async: got v=%b ic=%h a=%h b=%h d=%h cs=%b c16=%0d c4=%0d want all 0",
                              e_valid_o, e_icode_o, e_vala_o, e_valb_o, e_dstr_o, e_dstr_cs_o, cnt16, cnt4);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_c16 = 0; m_c4 = 0;
    endtask

    initial begin
        rst = 1'b1;
        m_c16 = 0; m_c4 = 0;
        test_reset();
        test_pass();
        test_load_use();
        test_alu_late();
        test_flush_stall();
        test_invalid_d();
        test_saturation();
        test_back_to_back();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
